// File: rtl/srl_fifo_ctrl_if.sv
// Handshake, flush and SRL-side signal bundle for srl_fifo_ctrl.
// The slave modport is the controller's view; the master modport is the surrounding logic.
interface srl_fifo_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             srl_ce;
  logic [WIDTH-1:0] srl_d;
  logic [3:0]       srl_addr;
  logic [WIDTH-1:0] srl_q;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             almost_full;

  modport slave (
    input  flush, in_valid, in_data, srl_q, out_ready,
    output in_ready, srl_ce, srl_d, srl_addr, out_valid, out_data, almost_full
  );

  modport master (
    output flush, in_valid, in_data, srl_q, out_ready,
    input  in_ready, srl_ce, srl_d, srl_addr, out_valid, out_data, almost_full
  );
endinterface

// File: rtl/srl_fifo_ctrl.sv
// Sequencing controller for an external SRL16E bank used as a shallow FIFO, with a registered output stage.
// Define SRL_FIFO_CTRL_ALMOST_FULL_EN to build the registered almost_full comparator.
module srl_fifo_ctrl #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = 12
) (
  input  logic           clk,
  input  logic           rst,
  srl_fifo_ctrl_if.slave bus
);

  if (DEPTH < 2 || DEPTH > 16) begin : g_bad_depth
    $error("srl_fifo_ctrl: DEPTH must be within 2..16");
  end
  if (AF_LEVEL > 31) begin : g_bad_af_level
    $error("srl_fifo_ctrl: AF_LEVEL does not fit the occupancy counter");
  end

  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  logic [4:0]       cnt_q;
  logic [4:0]       cnt_d;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             af_q;
  logic             in_ready;
  logic             push;
  logic             load;
  logic [3:0]       tail_addr;

  always_comb begin
    in_ready  = (cnt_q < DEPTH_C);
    push      = bus.in_valid & in_ready;
    load      = (cnt_q != '0) & (~out_valid_q | bus.out_ready);
    // cnt==16 wraps to 0 in 4 bits, so subtracting 1 still yields tap 15
    tail_addr = (cnt_q != '0) ? (cnt_q[3:0] - 4'd1) : '0;

    cnt_d = cnt_q;
    if (bus.flush) begin
      cnt_d = '0;
    end else if (push && !load) begin
      cnt_d = cnt_q + 5'd1;
    end else if (load && !push) begin
      cnt_d = cnt_q - 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (bus.flush) begin
        out_valid_q <= 1'b0;
      end else if (load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= bus.srl_q;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef SRL_FIFO_CTRL_ALMOST_FULL_EN
  localparam logic [4:0] AF_C = 5'(AF_LEVEL);

  // Registered from next occupancy so the flag lines up with the cycle cnt reaches the level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      af_q <= 1'b0;
    end else if (bus.flush) begin
      af_q <= 1'b0;
    end else begin
      af_q <= (cnt_d >= AF_C);
    end
  end
`else
  always_comb af_q = 1'b0;
`endif

  assign bus.in_ready    = in_ready;
  assign bus.srl_ce      = push;
  assign bus.srl_d       = bus.in_data;
  assign bus.srl_addr    = tail_addr;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.almost_full = af_q;

  a_cnt_bound: assert property (@(posedge clk) disable iff (rst) cnt_q <= DEPTH_C);
  a_no_empty_load: assert property (@(posedge clk) disable iff (rst) !(load && cnt_q == '0));

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// Scoreboard bench for srl_fifo_ctrl with a behavioural SRL16E bank and an occupancy reference model.
module tb_srl_fifo_ctrl;

  localparam int unsigned W = 8;
`ifdef SRL_FIFO_CTRL_ALMOST_FULL_EN
  localparam bit AF_EN = 1'b1;
`else
  localparam bit AF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  srl_fifo_ctrl_if #(.WIDTH(W)) bus ();

  srl_fifo_ctrl #(.WIDTH(W), .DEPTH(16), .AF_LEVEL(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [W-1:0] srl_mem [16];
  always @(posedge clk) begin
    if (bus.srl_ce) begin
      for (int i = 15; i > 0; i--) srl_mem[i] <= srl_mem[i-1];
      srl_mem[0] <= bus.srl_d;
    end
  end
  assign bus.srl_q = srl_mem[bus.srl_addr];

  int unsigned  n_tests = 0;
  int unsigned  n_fail  = 0;
  int unsigned  n_pushed = 0;
  logic [W-1:0] exp_q [$];
  int unsigned  mcnt = 0;
  bit           mov  = 1'b0;
  bit           maf  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    mcnt = 0;
    mov  = 1'b0;
    maf  = 1'b0;
  endtask

  // Observe the values presented to the coming rising edge and step the reference model
  always @(negedge clk) begin
    bit push_m, load_m;
    if (!rst) begin
      push_m = bus.in_valid && (mcnt < 16);
      load_m = (mcnt > 0) && (!mov || bus.out_ready);
      check("in_ready", bus.in_ready, (mcnt < 16));
      check("srl_ce", bus.srl_ce, push_m);
      check("srl_addr", bus.srl_addr, (mcnt > 0) ? mcnt - 1 : 0);
      check("out_valid", bus.out_valid, mov);
      check("almost_full", bus.almost_full, maf);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("sb_nonempty", exp_q.size(), 1);
        else check("out_data", bus.out_data, exp_q.pop_front());
      end
      if (bus.flush) begin
        exp_q.delete();
        mcnt = 0;
        mov  = 1'b0;
        maf  = 1'b0;
      end else begin
        if (push_m) begin
          exp_q.push_back(bus.in_data);
          n_pushed++;
        end
        if (push_m && !load_m) mcnt++;
        else if (load_m && !push_m) mcnt--;
        if (load_m) mov = 1'b1;
        else if (mov && bus.out_ready) mov = 1'b0;
        maf = AF_EN && (mcnt >= 12);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base;
    int unsigned budget;
    for (int i = 0; i < 16; i++) srl_mem[i] = '0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_almost_full", bus.almost_full, 0);
    check("rst_in_ready", bus.in_ready, 1);
    rst = 1'b0;
    tick();

    // Single word latency
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hA5;
    tick();
    bus.in_valid = 1'b0;
    check("lat_after_push", bus.out_valid, 0);
    tick();
    check("lat_valid", bus.out_valid, 1);
    check("lat_data", bus.out_data, 8'hA5);
    tick();
    check("lat_drained", bus.out_valid, 0);
    check("lat_ready", bus.in_ready, 1);

    // Fill to capacity with the consumer stalled, then drain
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    check("fill_in_ready", bus.in_ready, 0);
    check("fill_out_valid", bus.out_valid, 1);
    check("fill_out_data", bus.out_data, 8'h01);
    check("fill_almost_full", bus.almost_full, AF_EN);
    bus.out_ready = 1'b1;
    repeat (17) tick();
    check("drain_out_valid", bus.out_valid, 0);
    check("drain_sb_empty", exp_q.size(), 0);
    check("drain_almost_full", bus.almost_full, 0);

    // Continuous streaming
    for (int i = 0; i < 30; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(8'h40 + i);
      tick();
      if (i > 2) check("stream_no_bubble", bus.out_valid, 1);
    end
    bus.in_valid = 1'b0;
    repeat (3) tick();
    check("stream_sb_empty", exp_q.size(), 0);

    // Random valid/ready over 1000 accepted words
    base   = n_pushed;
    budget = 0;
    while ((n_pushed - base) < 1000 && budget < 20000) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = 8'($urandom);
      bus.out_ready = 1'($urandom_range(0, 1));
      tick();
      budget++;
    end
    check("rand_words", n_pushed - base, 1000);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    budget = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && budget < 40) begin
      tick();
      budget++;
    end
    check("rand_sb_empty", exp_q.size(), 0);

    // Flush with cnt=7 and a concurrent push
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(8'hC0 + i);
      tick();
    end
    bus.flush = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_out_valid", bus.out_valid, 0);
    check("flush_in_ready", bus.in_ready, 1);
    check("flush_srl_addr", bus.srl_addr, 0);
    tick();
    check("flush_no_load", bus.out_valid, 0);

    // Asynchronous reset pulse mid-stream
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(8'h70 + i);
      tick();
    end
    bus.in_valid = 1'b0;
    check("pre_rst_valid", bus.out_valid, 1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_valid", bus.out_valid, 0);
    check("async_rst_data", bus.out_data, 0);
    check("async_rst_ready", bus.in_ready, 1);
    rst = 1'b0;
    model_reset();
    repeat (3) tick();
    check("post_rst_valid", bus.out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
